exe_issue_ctrl: RTL and testbench

Synchronous issue/retire controller for the self-timed execute stage of the mousetrap pipeline. It takes instructions from a clocked valid/ready source and drives them onto the stage as bundled data with a two-phase `req`. It waits for the stage's two-phase `done`, captures `target_address`/`qual_branch`/`qual_regwrite`, and presents the captured result on a clocked valid/ready sink. It is the initiator/retire end of the stage's req/done protocol.

---
 rtl/exe_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_exe_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue_ctrl.sv
// Issue/retire controller for the self-timed execute stage: clocked valid/ready in,
// two-phase req/done to the stage, clocked valid/ready result out.
module exe_issue_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        req,
   output logic [31:0] instruction,
   input  logic        done,
   input  logic [31:0] target_address,
   input  logic        qual_branch,
   input  logic        qual_regwrite,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_target,
   output logic        out_branch,
   output logic        out_regwrite,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {StIdle, StArm, StWait, StHold} state_e;

   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] warm_q;
   logic                   req_q, req_d;
   logic [31:0]            instr_q, instr_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   timeout_q, timeout_d;
   logic [31:0]            tgt_q, tgt_d;
   logic                   br_q, br_d;
   logic                   rw_q, rw_d;
   logic                   done_s;
   logic                   phase_ok;

   assign done_s   = sync_q[SYNC_STAGES-1];
   assign phase_ok = (done_s == req_q);

   // warm_q fills with ones after reset so a stale synchronizer value is never
   // mistaken for phase agreement and used to issue a token.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         warm_q    <= '0;
         req_q     <= 1'b0;
         instr_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         tgt_q     <= '0;
         br_q      <= 1'b0;
         rw_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], done};
         warm_q    <= {warm_q[SYNC_STAGES-2:0], 1'b1};
         req_q     <= req_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         tgt_q     <= tgt_d;
         br_q      <= br_d;
         rw_q      <= rw_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      tgt_d     = tgt_q;
      br_d      = br_q;
      rw_d      = rw_q;
      in_ready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = warm_q[SYNC_STAGES-1] && phase_ok;
            if (in_valid && in_ready) begin
               instr_d = in_instr;
               state_d = StArm;
            end
         end
         StArm: begin
            req_d   = ~req_q;
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (phase_ok) begin
               tgt_d   = target_address;
               br_d    = qual_branch;
               rw_d    = qual_regwrite;
               state_d = StHold;
            end else begin
               // Saturate so a long-stuck stage cannot wrap the counter.
               if (cnt_q != TimeoutVal) cnt_d = cnt_q + 16'd1;
               if (cnt_q + 16'd1 == TimeoutVal) timeout_d = 1'b1;
            end
         end
         StHold: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign req          = req_q;
   assign instruction  = instr_q;
   assign out_valid    = (state_q == StHold);
   assign out_target   = tgt_q;
   assign out_branch   = br_q;
   assign out_regwrite = rw_q;
   assign busy         = (state_q != StIdle);
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl with a delayed-echo stage model on req/done.
module tb_exe_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        req;
   logic [31:0] instruction;
   logic        done;
   logic [31:0] target_address;
   logic        qual_branch;
   logic        qual_regwrite;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_target;
   logic        out_branch;
   logic        out_regwrite;
   logic        busy;
   logic        timeout;

   // Stage model: done echoes req after stage_dly, unless overridden by stuck/stuck_val.
   logic        model_done;
   logic        stuck;
   logic        stuck_val;
   logic        use_calc;
   logic [31:0] tb_target;
   int          stage_dly;

   int n_cmp;
   int n_err;

   assign done           = stuck ? stuck_val : model_done;
   assign target_address = use_calc ? instruction + 32'd4 : tb_target;

   exe_issue_ctrl #(
      .SYNC_STAGES(2),
      .TIMEOUT    (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .req           (req),
      .instruction   (instruction),
      .done          (done),
      .target_address(target_address),
      .qual_branch   (qual_branch),
      .qual_regwrite (qual_regwrite),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_target    (out_target),
      .out_branch    (out_branch),
      .out_regwrite  (out_regwrite),
      .busy          (busy),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(req) begin
      #(stage_dly);
      model_done = req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] ins);
      chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
      in_instr = ins;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int i;
      i = 0;
      while (!out_valid && i < 50) begin
         tick();
         i++;
      end
      chk(tag, {31'd0, out_valid}, 32'd1);
   endtask

   logic [31:0] instrs [4];
   int          tog_cyc [4];

   initial begin
      logic prev_req;
      logic acc;
      int   k, n, j;

      n_cmp = 0;      n_err = 0;
      rst_n = 1'b0;   in_valid = 1'b0;  in_instr = '0;  out_ready = 1'b1;
      model_done = 1'b0; stuck = 1'b0;  stuck_val = 1'b0; use_calc = 1'b0;
      tb_target = '0; qual_branch = 1'b0; qual_regwrite = 1'b0; stage_dly = 15;
      instrs[0] = 32'h1111_0000; instrs[1] = 32'h2222_0010;
      instrs[2] = 32'h3333_0020; instrs[3] = 32'h4444_0030;

      // Reset values
      tick();
      chk("rst_req",      {31'd0, req},       32'd0);
      chk("rst_instr",    instruction,        32'd0);
      chk("rst_in_ready", {31'd0, in_ready},  32'd0);
      chk("rst_out_valid",{31'd0, out_valid}, 32'd0);
      chk("rst_busy",     {31'd0, busy},      32'd0);
      chk("rst_timeout",  {31'd0, timeout},   32'd0);
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Test 1: CAFEBABE
      tb_target = 32'h0; qual_branch = 1'b1; qual_regwrite = 1'b0;
      issue(32'hCAFEBABE);
      chk("t1_arm_instr", instruction,        32'hCAFEBABE);
      chk("t1_arm_req",   {31'd0, req},       32'd0);
      chk("t1_arm_busy",  {31'd0, busy},      32'd1);
      tick();
      chk("t1_req_rise",  {31'd0, req},       32'd1);
      wait_valid("t1_out_valid");
      chk("t1_branch",    {31'd0, out_branch},   32'd1);
      chk("t1_regwrite",  {31'd0, out_regwrite}, 32'd0);
      chk("t1_target",    out_target,            32'h0);
      tick();
      chk("t1_idle",      {31'd0, busy},      32'd0);

      // Test 2: 12345678, instruction stable through WAIT
      tb_target = 32'hDEAFBEEF; qual_branch = 1'b0; qual_regwrite = 1'b1;
      issue(32'h12345678);
      k = 0;
      while (!out_valid && k < 50) begin
         chk("t2_instr_stable", instruction, 32'h12345678);
         tick();
         k++;
      end
      chk("t2_out_valid", {31'd0, out_valid},    32'd1);
      chk("t2_instr_hold",instruction,           32'h12345678);
      chk("t2_target",    out_target,            32'hDEAFBEEF);
      chk("t2_branch",    {31'd0, out_branch},   32'd0);
      chk("t2_regwrite",  {31'd0, out_regwrite}, 32'd1);
      chk("t2_req",       {31'd0, req},          32'd0);
      tick();

      // Test 3: four back-to-back tokens, immediate stage response
      use_calc = 1'b1; stage_dly = 1;
      prev_req = req; k = 0; n = 0; j = 0;
      in_instr = instrs[0]; in_valid = 1'b1;
      for (int c = 1; c <= 60 && j < 4; c++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            k++;
            if (k < 4) in_instr = instrs[k];
            else in_valid = 1'b0;
         end
         if (req !== prev_req && n < 4) begin
            tog_cyc[n] = c;
            chk("t3_req_value", {31'd0, req}, (n % 2 == 0) ? 32'd1 : 32'd0);
            n++;
         end
         prev_req = req;
         if (out_valid && j < 4) begin
            chk("t3_order", out_target, instrs[j] + 32'd4);
            j++;
         end
      end
      in_valid = 1'b0;
      chk("t3_toggles", n, 32'd4);
      chk("t3_results", j, 32'd4);
      for (int i = 0; i < 3; i++) chk("t3_spacing", tog_cyc[i+1] - tog_cyc[i], 32'd6);
      tick();

      // Test 4: backpressure in HOLD
      use_calc = 1'b0; stage_dly = 15; out_ready = 1'b0;
      tb_target = 32'h0BAD_F00D; qual_branch = 1'b1; qual_regwrite = 1'b1;
      issue(32'hA5A5_0001);
      wait_valid("t4_out_valid");
      prev_req = req;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_valid",  {31'd0, out_valid}, 32'd1);
         chk("t4_hold_target", out_target,         32'h0BAD_F00D);
         chk("t4_hold_ready",  {31'd0, in_ready},  32'd0);
         chk("t4_hold_req",    {31'd0, req},       {31'd0, prev_req});
      end
      out_ready = 1'b1;
      tick();
      chk("t4_release_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_release_ready", {31'd0, in_ready},  32'd1);

      // Test 5: timeout with done stuck (req currently 1, done 1)
      stuck = 1'b1; stuck_val = 1'b1;
      tb_target = 32'h7777_0005; qual_branch = 1'b0; qual_regwrite = 1'b0;
      issue(32'h0000_0055);
      tick();
      chk("t5_req", {31'd0, req}, 32'd0);
      for (int i = 0; i < 15; i++) tick();
      chk("t5_timeout_early", {31'd0, timeout}, 32'd0);
      tick();
      chk("t5_timeout_set",   {31'd0, timeout},   32'd1);
      chk("t5_still_wait",    {31'd0, busy},      32'd1);
      chk("t5_no_valid",      {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("t5_still_wait2",   {31'd0, out_valid}, 32'd0);
      stuck_val = 1'b0;
      wait_valid("t5_late_done");
      chk("t5_target",        out_target,         32'h7777_0005);
      chk("t5_timeout_stick", {31'd0, timeout},   32'd1);
      tick();
      chk("t5_timeout_idle",  {31'd0, timeout},   32'd1);

      // Test 6: reset mid-WAIT while the stage is not reset
      tick(); tick();
      issue(32'hBEEF_0006);
      tick(); tick(); tick();
      chk("t6_in_wait", {31'd0, busy}, 32'd1);
      rst_n = 1'b0; stuck_val = 1'b1;
      #1;
      chk("t6_rst_req",      {31'd0, req},          32'd0);
      chk("t6_rst_instr",    instruction,           32'd0);
      chk("t6_rst_in_ready", {31'd0, in_ready},     32'd0);
      chk("t6_rst_valid",    {31'd0, out_valid},    32'd0);
      chk("t6_rst_target",   out_target,            32'd0);
      chk("t6_rst_branch",   {31'd0, out_branch},   32'd0);
      chk("t6_rst_regwrite", {31'd0, out_regwrite}, 32'd0);
      chk("t6_rst_busy",     {31'd0, busy},         32'd0);
      chk("t6_rst_timeout",  {31'd0, timeout},      32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("t6_mismatch_1", {31'd0, in_ready}, 32'd0);
      tick(); tick(); tick();
      chk("t6_mismatch_4", {31'd0, in_ready}, 32'd0);
      stuck_val = 1'b0;
      tick();
      chk("t6_sync_lag",   {31'd0, in_ready}, 32'd0);
      tick(); tick();
      chk("t6_matched",    {31'd0, in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
